// File: rtl/drive_z_corr_loader.sv
// Write-side loader for the drive Z-correction tables: header + TOTAL_QUBIT beats -> one row write.
// Optional bank-clear sweep (cfg_clear input, CLEAR state) enabled by Z_CORR_LOADER_CLEAR_EN.
module drive_z_corr_loader #(
    parameter int unsigned NUM_BANK                  = 2,
    parameter int unsigned NUM_QUBIT_PER_BANK        = 16,
    parameter int unsigned QUBIT_ADDR_WIDTH_PER_BANK = 4,
    parameter int unsigned Z_CORR_WIDTH              = 12,
    parameter int unsigned BANK_SEL_WIDTH            = 1,
    localparam int unsigned TOTAL_QUBIT = NUM_BANK * NUM_QUBIT_PER_BANK,
    localparam int unsigned DATA_WIDTH  = Z_CORR_WIDTH * TOTAL_QUBIT,
    localparam int unsigned ADDR_WIDTH  = QUBIT_ADDR_WIDTH_PER_BANK
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [BANK_SEL_WIDTH-1:0] cfg_bank,
    input  logic [ADDR_WIDTH-1:0]     cfg_addr,
`ifdef Z_CORR_LOADER_CLEAR_EN
    input  logic                      cfg_clear,
`endif
    input  logic                      coef_valid,
    output logic                      coef_ready,
    input  logic [Z_CORR_WIDTH-1:0]   coef_data,
    input  logic [NUM_BANK-1:0]       bank_busy,
    output logic [NUM_BANK-1:0]       z_corr_memory_wr_sel,
    output logic                      z_corr_memory_wr_en,
    output logic [ADDR_WIDTH-1:0]     z_corr_memory_wr_addr,
    output logic [DATA_WIDTH-1:0]     z_corr_memory_wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int unsigned BEAT_W = (TOTAL_QUBIT > 1) ? $clog2(TOTAL_QUBIT) : 1;
    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(TOTAL_QUBIT - 1);
    localparam logic [NUM_BANK-1:0] BANK_ONE  = NUM_BANK'(1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StCollect  = 2'd1;
    localparam logic [1:0] StWaitBank = 2'd2;
`ifdef Z_CORR_LOADER_CLEAR_EN
    localparam logic [1:0] StClear    = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = ADDR_WIDTH'(NUM_QUBIT_PER_BANK - 1);
`endif

    logic [1:0]                state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [DATA_WIDTH-1:0]     row_q, row_d;
    logic [BANK_SEL_WIDTH-1:0] bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic                      err_q, err_d;
    logic                      hdr_fire, beat_fire, bank_bad, bank_free, wr_en;
    logic [NUM_BANK-1:0]       bank_oh;

    assign cfg_ready  = (state_q == StIdle);
    assign coef_ready = (state_q == StCollect);
    assign hdr_fire   = cfg_valid & cfg_ready;
    assign beat_fire  = coef_valid & coef_ready;
    assign bank_bad   = 32'(cfg_bank) >= NUM_BANK;
    assign bank_oh    = BANK_ONE << bank_q;
    // Only the latched bank's read launch gates the write; other banks are ignored.
    assign bank_free  = ~|(bank_oh & bank_busy);

    always_comb begin
        wr_en = 1'b0;
        done  = 1'b0;
        if (state_q == StWaitBank) begin
            wr_en = bank_free;
            done  = bank_free;
        end
`ifdef Z_CORR_LOADER_CLEAR_EN
        if (state_q == StClear) begin
            wr_en = bank_free;
            done  = bank_free & (addr_q == LAST_ENTRY);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        row_d   = row_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (hdr_fire) begin
                    bank_d = cfg_bank;
                    addr_d = cfg_addr;
                    row_d  = '0;
                    beat_d = '0;
                    if (bank_bad) begin
                        err_d = 1'b1;
                    end
`ifdef Z_CORR_LOADER_CLEAR_EN
                    else if (cfg_clear) begin
                        // Sweep reuses the cleared row buffer and the address register.
                        addr_d  = '0;
                        state_d = StClear;
                    end
`endif
                    else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (beat_fire) begin
                    row_d[beat_q*Z_CORR_WIDTH +: Z_CORR_WIDTH] = coef_data;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = StWaitBank;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StWaitBank: begin
                if (wr_en) begin
                    state_d = StIdle;
                end
            end
`ifdef Z_CORR_LOADER_CLEAR_EN
            StClear: begin
                if (wr_en) begin
                    if (addr_q == LAST_ENTRY) begin
                        state_d = StIdle;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            row_q   <= '0;
            bank_q  <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign z_corr_memory_wr_en   = wr_en;
    assign z_corr_memory_wr_sel  = wr_en ? bank_oh : '0;
    assign z_corr_memory_wr_addr = addr_q;
    assign z_corr_memory_wr_data = row_q;
    assign busy                  = (state_q != StIdle);
    assign err                   = err_q;

endmodule

// File: tb/tb_drive_z_corr_loader.sv
// Scoreboard bench for drive_z_corr_loader: drivers push expected writes, a negedge monitor checks.
`timescale 1ns/1ps
module tb_drive_z_corr_loader;
    localparam int NB = 2;
    localparam int NQ = 16;
    localparam int AW = 4;
    localparam int ZW = 12;
    localparam int BW = 2;
    localparam int TQ = NB * NQ;
    localparam int DW = ZW * TQ;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [BW-1:0] cfg_bank = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic          cfg_clear = 1'b0;
    logic          coef_valid = 1'b0;
    logic          coef_ready;
    logic [ZW-1:0] coef_data = '0;
    logic [NB-1:0] bank_busy;
    logic [NB-1:0] wr_sel;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done, err;
    logic          busy0 = 1'b0, busy1 = 1'b0, tog_en = 1'b0;

    assign bank_busy = {busy1, busy0};

    always #5 clk = ~clk;

    drive_z_corr_loader #(
        .NUM_BANK                  (NB),
        .NUM_QUBIT_PER_BANK        (NQ),
        .QUBIT_ADDR_WIDTH_PER_BANK (AW),
        .Z_CORR_WIDTH              (ZW),
        .BANK_SEL_WIDTH            (BW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cfg_valid             (cfg_valid),
        .cfg_ready             (cfg_ready),
        .cfg_bank              (cfg_bank),
        .cfg_addr              (cfg_addr),
`ifdef Z_CORR_LOADER_CLEAR_EN
        .cfg_clear             (cfg_clear),
`endif
        .coef_valid            (coef_valid),
        .coef_ready            (coef_ready),
        .coef_data             (coef_data),
        .bank_busy             (bank_busy),
        .z_corr_memory_wr_sel  (wr_sel),
        .z_corr_memory_wr_en   (wr_en),
        .z_corr_memory_wr_addr (wr_addr),
        .z_corr_memory_wr_data (wr_data),
        .busy                  (busy),
        .done                  (done),
        .err                   (err)
    );

    typedef struct {
        logic [NB-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        int            lat;   // header-to-write cycles, -1 when stalls make it unknown
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   hdr_cyc = 0;
    int   err_cyc = -10;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        fails++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    function automatic logic [DW-1:0] make_row(input int base);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < TQ; k++) r[k*ZW +: ZW] = ZW'(base + k);
        return r;
    endfunction

    task automatic push_exp(input int bank, input int addr, input logic [DW-1:0] data,
                            input bit last, input int lat);
        exp_t e;
        e.sel  = NB'(1) << bank;
        e.addr = AW'(addr);
        e.data = data;
        e.last = last;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops and compares each write.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            err_cyc = -10;
        end else begin
            check("err_pulse", DW'(err), DW'(cyc == err_cyc));
            if (cfg_valid && cfg_ready) begin
                hdr_cyc = cyc;
                if (int'(cfg_bank) >= NB) err_cyc = cyc + 1;
            end
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    check("wr_sel", DW'(wr_sel), DW'(e.sel));
                    check("wr_addr", DW'(wr_addr), DW'(e.addr));
                    check("wr_data", wr_data, e.data);
                    check("done", DW'(done), DW'(e.last));
                    check("target_not_busy", DW'(bank_busy & wr_sel), '0);
                    if (e.lat >= 0) check("latency", DW'(cyc - hdr_cyc), DW'(e.lat));
                end
            end else begin
                check("idle_sel", DW'(wr_sel), '0);
                check("idle_done", DW'(done), '0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        busy0 = tog_en ? ~busy0 : 1'b0;
    end

    task automatic hdr(input int b, input int a, input bit clr);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_bank  = BW'(b);
        cfg_addr  = AW'(a);
        cfg_clear = clr;
        while (!cfg_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cfg_ready) flag("hdr_timeout");
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
    endtask

    task automatic beats(input int duty, input int n_beats, input int base);
        bit acc, v;
        int n;
        for (int k = 0; k < n_beats; k++) begin
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 1000) begin
                v          = ($urandom_range(99) < duty);
                coef_valid = v;
                coef_data  = v ? ZW'(base + k) : ZW'($urandom);
                acc        = v && coef_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) flag("beat_timeout");
        end
        coef_valid = 1'b0;
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) flag("idle_timeout");
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_cfg_ready"}, DW'(cfg_ready), DW'(1));
        check({tag, "_coef_ready"}, DW'(coef_ready), '0);
        check({tag, "_wr_en"}, DW'(wr_en), '0);
        check({tag, "_wr_sel"}, DW'(wr_sel), '0);
        check({tag, "_wr_addr"}, DW'(wr_addr), '0);
        check({tag, "_wr_data"}, wr_data, '0);
        check({tag, "_busy"}, DW'(busy), '0);
        check({tag, "_done"}, DW'(done), '0);
        check({tag, "_err"}, DW'(err), '0);
    endtask

    initial begin
        int b, a, base;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outs("after_reset");

        // Plain load, no stalls.
        push_exp(1, 5, make_row(1), 1'b1, 33);
        hdr(1, 5, 1'b0);
        check("collect_cfg_ready", DW'(cfg_ready), '0);
        check("collect_coef_ready", DW'(coef_ready), DW'(1));
        beats(100, TQ, 1);
        wait_idle();

        // Target bank busy 7 cycles in WAIT_BANK, other bank toggling.
        push_exp(1, 7, make_row(40), 1'b1, 40);
        busy1  = 1'b1;
        tog_en = 1'b1;
        hdr(1, 7, 1'b0);
        beats(100, TQ, 40);
        check("wait_coef_ready", DW'(coef_ready), '0);
        check("wait_cfg_ready", DW'(cfg_ready), '0);
        check("wait_busy", DW'(busy), DW'(1));
        repeat (7) begin @(posedge clk); #1; end
        busy1 = 1'b0;
        wait_idle();
        tog_en = 1'b0;

        // Busy on the other bank does not block.
        busy1 = 1'b1;
        push_exp(0, 2, make_row(300), 1'b1, 33);
        @(posedge clk); #1;
        hdr(0, 2, 1'b0);
        beats(100, TQ, 300);
        wait_idle();
        busy1 = 1'b0;

        // Random gaps, stray header and beats outside their states.
        push_exp(1, 5, make_row(1), 1'b1, -1);
        hdr(1, 5, 1'b0);
        cfg_valid = 1'b1;
        cfg_bank  = '0;
        cfg_addr  = AW'(9);
        beats(50, TQ, 1);
        coef_valid = 1'b1;
        coef_data  = ZW'(12'hABC);
        wait_idle();
        coef_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b    = int'($urandom_range(1));
            a    = int'($urandom_range(NQ - 1));
            base = int'($urandom_range(4000));
            push_exp(b, a, make_row(base), 1'b1, -1);
            hdr(b, a, 1'b0);
            beats(50, TQ, base);
            wait_idle();
        end

        // Out-of-range bank, then a normal header.
        hdr(3, 2, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("bad_bank_idle", DW'(busy), '0);
        push_exp(0, 3, make_row(77), 1'b1, 33);
        hdr(0, 3, 1'b0);
        beats(100, TQ, 77);
        wait_idle();

        // Reset mid-load discards the partial row.
        hdr(1, 9, 1'b0);
        beats(100, 10, 50);
        rst = 1'b1;
        #2;
        check_reset_outs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(0, 12, make_row(200), 1'b1, 33);
        hdr(0, 12, 1'b0);
        beats(100, TQ, 200);
        wait_idle();

`ifdef Z_CORR_LOADER_CLEAR_EN
        // Bank clear sweep: cfg_addr ignored, zero rows to every entry.
        for (int i = 0; i < NQ; i++) push_exp(0, i, '0, (i == NQ - 1), i + 1);
        hdr(0, 9, 1'b1);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", DW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
